// File: rtl/disp_credit_ctrl_pkg.sv
// Shared types and constants for the dispatch credit controller.
// Stall-reason bit order is {br, imm, memdq, intdq, rob}.
package disp_credit_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } dispCtrlState_t;

  localparam int STALL_ROB   = 0;
  localparam int STALL_INTDQ = 1;
  localparam int STALL_MEMDQ = 2;
  localparam int STALL_IMM   = 3;
  localparam int STALL_BR    = 4;
  localparam int NUM_RES     = 5;

  localparam int ROB_SIZE   = 64;
  localparam int INTDQ_SIZE = 16;
  localparam int MEMDQ_SIZE = 16;
  localparam int IMMB_SIZE  = 30;
  localparam int BRB_SIZE   = 30;

endpackage

// File: rtl/disp_credit_ctrl_credit.sv
// Free-slot counter for one dispatch resource.
// Holds credit - consumed + returned; can be reloaded to full.
module credit_counter #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_consume,
  input  logic [CNT_W-1:0] i_return,
  input  logic             i_load_full,
  output logic [CW-1:0]    o_credit
);

  logic [CW-1:0] r_credit;
  logic [CW:0]   w_sum;

  // One extra bit so an over-return is visible to the check below.
  assign w_sum    = {1'b0, r_credit} - (CW+1)'(i_consume) + (CW+1)'(i_return);
  assign o_credit = r_credit;

  always_ff @(posedge clk) begin
    if (rst || i_load_full) r_credit <= CW'(DEPTH);
    else                    r_credit <= w_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_load_full)
      assert (w_sum <= (CW+1)'(DEPTH))
        else $error("credit_counter DEPTH=%0d overflow: credit=%0d consume=%0d return=%0d",
                    DEPTH, r_credit, i_consume, i_return);
  end

endmodule

// File: rtl/disp_credit_ctrl.sv
// Grants the longest in-order prefix of the rename group that fits every
// resource's credit, and holds dispatch off through squash recovery.
module disp_credit_ctrl
  import disp_credit_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ROB_DEPTH   = ROB_SIZE,
  parameter int INTDQ_DEPTH = INTDQ_SIZE,
  parameter int MEMDQ_DEPTH = MEMDQ_SIZE,
  parameter int IMMB_DEPTH  = IMMB_SIZE,
  parameter int BRB_DEPTH   = BRB_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_squash_vld,
  input  logic                         i_recover_done,
  input  logic [WIDTH-1:0]             i_enq_vld,
  input  logic [WIDTH-1:0]             i_need_rob,
  input  logic [WIDTH-1:0]             i_need_intdq,
  input  logic [WIDTH-1:0]             i_need_memdq,
  input  logic [WIDTH-1:0]             i_need_imm,
  input  logic [WIDTH-1:0]             i_need_br,
  input  logic [$clog2(WIDTH+1)-1:0]   i_ret_rob,
  input  logic [$clog2(WIDTH+1)-1:0]   i_ret_intdq,
  input  logic [$clog2(WIDTH+1)-1:0]   i_ret_memdq,
  input  logic [$clog2(WIDTH+1)-1:0]   i_ret_imm,
  input  logic [$clog2(WIDTH+1)-1:0]   i_ret_br,
  output logic [WIDTH-1:0]             o_disp_vld,
  output logic                         o_can_enq,
  output logic [NUM_RES-1:0]           o_stall_reason,
  output logic                         o_busy,
  output dispCtrlState_t               o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  dispCtrlState_t r_state, w_state_next;

  logic [NUM_RES-1:0][WIDTH-1:0] w_need;
  logic [CNT_W-1:0]              w_ret     [NUM_RES];
  logic [CNT_W-1:0]              w_consume [NUM_RES];
  logic [31:0]                   w_credit  [NUM_RES];
  logic [31:0]                   w_run_cnt [NUM_RES];
  logic [NUM_RES-1:0]            w_fail;
  logic [WIDTH-1:0]              w_disp_vld;
  logic [NUM_RES-1:0]            w_stall;
  logic                          w_blocked;
  logic                          w_dispatch_en;
  logic                          w_flush_load;

  logic [$clog2(ROB_DEPTH+1)-1:0]   w_rob_credit;
  logic [$clog2(INTDQ_DEPTH+1)-1:0] w_intdq_credit;
  logic [$clog2(MEMDQ_DEPTH+1)-1:0] w_memdq_credit;
  logic [$clog2(IMMB_DEPTH+1)-1:0]  w_imm_credit;
  logic [$clog2(BRB_DEPTH+1)-1:0]   w_br_credit;

  assign w_need[STALL_ROB]   = i_need_rob;
  assign w_need[STALL_INTDQ] = i_need_intdq;
  assign w_need[STALL_MEMDQ] = i_need_memdq;
  assign w_need[STALL_IMM]   = i_need_imm;
  assign w_need[STALL_BR]    = i_need_br;

  assign w_ret[STALL_ROB]   = i_ret_rob;
  assign w_ret[STALL_INTDQ] = i_ret_intdq;
  assign w_ret[STALL_MEMDQ] = i_ret_memdq;
  assign w_ret[STALL_IMM]   = i_ret_imm;
  assign w_ret[STALL_BR]    = i_ret_br;

  assign w_credit[STALL_ROB]   = 32'(w_rob_credit);
  assign w_credit[STALL_INTDQ] = 32'(w_intdq_credit);
  assign w_credit[STALL_MEMDQ] = 32'(w_memdq_credit);
  assign w_credit[STALL_IMM]   = 32'(w_imm_credit);
  assign w_credit[STALL_BR]    = 32'(w_br_credit);

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    w_state_next = RUN;
      RUN:     if (i_squash_vld) w_state_next = FLUSH;
      FLUSH:   w_state_next = i_squash_vld ? FLUSH : RECOVER;
      RECOVER: begin
        if (i_squash_vld)        w_state_next = FLUSH;
        else if (i_recover_done) w_state_next = RUN;
      end
      default: w_state_next = INIT;
    endcase
  end

  assign w_dispatch_en = (r_state == RUN) && !i_squash_vld;
  // The dispatch queues are emptied by the squash itself, so their credits
  // reload on the way into FLUSH and again while in it.
  assign w_flush_load  = (r_state == FLUSH) || (w_state_next == FLUSH);

  // Walk the slots in order with running per-resource demand; the first
  // slot that is invalid or does not fit ends the granted prefix.
  always_comb begin
    w_disp_vld = '0;
    w_stall    = '0;
    w_fail     = '0;
    w_blocked  = !w_dispatch_en;
    for (int r = 0; r < NUM_RES; r++) w_run_cnt[r] = '0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int r = 0; r < NUM_RES; r++) begin
        w_run_cnt[r] = w_run_cnt[r] + 32'(w_need[r][k]);
        w_fail[r]    = w_run_cnt[r] > w_credit[r];
      end
      if (!w_blocked && i_enq_vld[k] && (w_fail == '0)) begin
        w_disp_vld[k] = 1'b1;
      end else begin
        if (!w_blocked && i_enq_vld[k]) w_stall = w_fail;
        w_blocked = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RES; r++) begin
      w_consume[r] = '0;
      for (int k = 0; k < WIDTH; k++)
        w_consume[r] = w_consume[r] + CNT_W'(w_need[r][k] & w_disp_vld[k]);
    end
  end

  assign o_disp_vld     = w_disp_vld;
  assign o_can_enq      = w_dispatch_en && (w_disp_vld == i_enq_vld);
  assign o_stall_reason = w_stall;
  assign o_busy         = (r_state != RUN);
  assign o_dbg_state    = r_state;

  credit_counter #(.DEPTH(ROB_DEPTH), .CNT_W(CNT_W)) u_rob_credit (
    .clk(clk), .rst(rst), .i_consume(w_consume[STALL_ROB]), .i_return(w_ret[STALL_ROB]),
    .i_load_full(1'b0), .o_credit(w_rob_credit));

  credit_counter #(.DEPTH(INTDQ_DEPTH), .CNT_W(CNT_W)) u_intdq_credit (
    .clk(clk), .rst(rst), .i_consume(w_consume[STALL_INTDQ]), .i_return(w_ret[STALL_INTDQ]),
    .i_load_full(w_flush_load), .o_credit(w_intdq_credit));

  credit_counter #(.DEPTH(MEMDQ_DEPTH), .CNT_W(CNT_W)) u_memdq_credit (
    .clk(clk), .rst(rst), .i_consume(w_consume[STALL_MEMDQ]), .i_return(w_ret[STALL_MEMDQ]),
    .i_load_full(w_flush_load), .o_credit(w_memdq_credit));

  credit_counter #(.DEPTH(IMMB_DEPTH), .CNT_W(CNT_W)) u_imm_credit (
    .clk(clk), .rst(rst), .i_consume(w_consume[STALL_IMM]), .i_return(w_ret[STALL_IMM]),
    .i_load_full(1'b0), .o_credit(w_imm_credit));

  credit_counter #(.DEPTH(BRB_DEPTH), .CNT_W(CNT_W)) u_br_credit (
    .clk(clk), .rst(rst), .i_consume(w_consume[STALL_BR]), .i_return(w_ret[STALL_BR]),
    .i_load_full(1'b0), .o_credit(w_br_credit));

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (((i_enq_vld + WIDTH'(1)) & i_enq_vld) == '0)
        else $error("disp_credit_ctrl: non-contiguous i_enq_vld %b", i_enq_vld);
      for (int r = 0; r < NUM_RES; r++)
        assert ((w_need[r] & ~i_enq_vld) == '0)
          else $error("disp_credit_ctrl: need[%0d]=%b on invalid slot, enq=%b", r, w_need[r], i_enq_vld);
    end
  end

endmodule

// File: tb/tb_disp_credit_ctrl.sv
// Directed bench for disp_credit_ctrl: stimulus pushes hand-computed outputs
// into a queue; a negedge monitor pops and compares every cycle.
module tb_disp_credit_ctrl;
  import disp_credit_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 squash, rdone;
  logic [3:0]           enq, n_rob, n_int, n_mem, n_imm, n_br;
  logic [2:0]           r_rob, r_int, r_mem, r_imm, r_br;
  logic [3:0]           disp_vld;
  logic                 can_enq, busy;
  logic [4:0]           stall;
  dispCtrlState_t       dbg_state;

  // {disp_vld[3:0], can_enq, stall[4:0], busy, state[1:0]}
  logic [12:0] exp_q[$];
  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  disp_credit_ctrl dut (
    .clk(clk), .rst(rst), .i_squash_vld(squash), .i_recover_done(rdone),
    .i_enq_vld(enq), .i_need_rob(n_rob), .i_need_intdq(n_int), .i_need_memdq(n_mem),
    .i_need_imm(n_imm), .i_need_br(n_br), .i_ret_rob(r_rob), .i_ret_intdq(r_int),
    .i_ret_memdq(r_mem), .i_ret_imm(r_imm), .i_ret_br(r_br), .o_disp_vld(disp_vld),
    .o_can_enq(can_enq), .o_stall_reason(stall), .o_busy(busy), .o_dbg_state(dbg_state));

  task automatic clear_inputs();
    squash = 1'b0; rdone = 1'b0;
    enq = '0; n_rob = '0; n_int = '0; n_mem = '0; n_imm = '0; n_br = '0;
    r_rob = '0; r_int = '0; r_mem = '0; r_imm = '0; r_br = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input logic [3:0] d, input logic c, input logic [4:0] s,
                            input dispCtrlState_t st);
    logic [1:0] st_bits;
    st_bits = st;
    exp_q.push_back({d, c, s, (st != RUN), st_bits});
  endtask

  always @(negedge clk) begin
    logic [12:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {disp_vld, can_enq, stall, busy, 2'(dbg_state)};
      total_cnt++;
      if (got_v !== exp_v) begin
        bad_cnt++;
        $display("FAIL outputs t=%0t {disp,can,stall,busy,state} got=%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b",
                 $time, got_v[12:9], got_v[8], got_v[7:3], got_v[2], got_v[1:0],
                 exp_v[12:9], exp_v[8], exp_v[7:3], exp_v[2], exp_v[1:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset and the single INIT cycle; INIT must not grant even with demand.
    tick(); expect_out(4'b0000, 0, 5'b00000, INIT);
    tick(); expect_out(4'b0000, 0, 5'b00000, INIT);
    tick(); rst = 1'b0; enq = 4'hF; n_rob = 4'hF; expect_out(4'b0000, 0, 5'b00000, INIT);

    // ROB: 64 -> 60 -> ... -> 0, then blocked, then same-cycle return is invisible.
    tick(); enq = 4'hF; n_rob = 4'hF; expect_out(4'b1111, 1, 5'b00000, RUN);
    for (int i = 0; i < 15; i++) begin
      tick(); enq = 4'hF; n_rob = 4'hF; expect_out(4'b1111, 1, 5'b00000, RUN);
    end
    tick(); enq = 4'hF; n_rob = 4'hF; expect_out(4'b0000, 0, 5'b00001, RUN);
    tick(); enq = 4'hF; n_rob = 4'hF; r_rob = 3'd3; expect_out(4'b0000, 0, 5'b00001, RUN);
    tick(); enq = 4'hF; n_rob = 4'hF; expect_out(4'b0111, 0, 5'b00001, RUN);

    // intdq drained to 2 (imm and br drain alongside), then a partial grant.
    for (int i = 0; i < 3; i++) begin
      tick(); enq = 4'hF; n_int = 4'hF; n_imm = 4'hF; n_br = 4'hF;
      expect_out(4'b1111, 1, 5'b00000, RUN);
    end
    tick(); enq = 4'h3; n_int = 4'h3; n_imm = 4'h3; n_br = 4'h3; expect_out(4'b0011, 1, 5'b00000, RUN);
    tick(); enq = 4'hF; n_int = 4'hF; expect_out(4'b0011, 0, 5'b00010, RUN);

    // imm down to 1, br down to 1, then the mixed-need group.
    for (int i = 0; i < 3; i++) begin
      tick(); enq = 4'hF; n_imm = 4'hF; n_br = 4'hF; expect_out(4'b1111, 1, 5'b00000, RUN);
    end
    tick(); enq = 4'h7; n_imm = 4'h7; n_br = 4'h7; expect_out(4'b0111, 1, 5'b00000, RUN);
    tick(); enq = 4'hF; n_imm = 4'b0110; n_br = 4'b0001; expect_out(4'b0011, 0, 5'b01000, RUN);

    // br credit 0 with a same-cycle return of 3; visible one cycle later.
    tick(); enq = 4'h1; n_br = 4'h1; r_br = 3'd3; expect_out(4'b0000, 0, 5'b10000, RUN);
    tick(); enq = 4'h1; n_br = 4'h1; expect_out(4'b0001, 1, 5'b00000, RUN);

    // Empty group in RUN is fully accepted; intdq credit goes 0 -> 5.
    tick(); r_int = 3'd5; expect_out(4'b0000, 1, 5'b00000, RUN);

    // Squash with intdq=5, long RECOVER with rob returns (rob 0 -> 5).
    tick(); squash = 1'b1; enq = 4'hF; n_int = 4'h1; expect_out(4'b0000, 0, 5'b00000, RUN);
    tick(); enq = 4'hF; n_int = 4'hF; expect_out(4'b0000, 0, 5'b00000, FLUSH);
    for (int i = 0; i < 10; i++) begin
      tick(); enq = 4'hF; n_rob = 4'hF;
      if (i < 5) r_rob = 3'd1;
      expect_out(4'b0000, 0, 5'b00000, RECOVER);
    end
    tick(); rdone = 1'b1; expect_out(4'b0000, 0, 5'b00000, RECOVER);
    tick(); enq = 4'hF; n_rob = 4'hF; n_int = 4'hF; expect_out(4'b1111, 1, 5'b00000, RUN);
    tick(); enq = 4'hF; n_rob = 4'b0011; n_int = 4'hF; expect_out(4'b0001, 0, 5'b00001, RUN);
    for (int i = 0; i < 2; i++) begin
      tick(); enq = 4'hF; n_int = 4'hF; expect_out(4'b1111, 1, 5'b00000, RUN);
    end
    tick(); enq = 4'hF; n_int = 4'hF; expect_out(4'b0111, 0, 5'b00010, RUN);

    // Squash and recover_done together in RECOVER: squash wins.
    tick(); squash = 1'b1; expect_out(4'b0000, 0, 5'b00000, RUN);
    tick(); expect_out(4'b0000, 0, 5'b00000, FLUSH);
    tick(); squash = 1'b1; rdone = 1'b1; expect_out(4'b0000, 0, 5'b00000, RECOVER);
    tick(); rdone = 1'b1; expect_out(4'b0000, 0, 5'b00000, FLUSH);
    tick(); rdone = 1'b1; expect_out(4'b0000, 0, 5'b00000, RECOVER);
    tick(); expect_out(4'b0000, 1, 5'b00000, RUN);

    // Reset in RECOVER: pending returns dropped, every credit back to full.
    tick(); squash = 1'b1; expect_out(4'b0000, 0, 5'b00000, RUN);
    tick(); expect_out(4'b0000, 0, 5'b00000, FLUSH);
    tick(); r_rob = 3'd2; expect_out(4'b0000, 0, 5'b00000, RECOVER);
    tick(); rst = 1'b1; r_rob = 3'd3; enq = 4'hF; n_rob = 4'hF; expect_out(4'b0000, 0, 5'b00000, RECOVER);
    tick(); rst = 1'b0; enq = 4'hF; n_rob = 4'hF; expect_out(4'b0000, 0, 5'b00000, INIT);
    for (int i = 0; i < 16; i++) begin
      tick(); enq = 4'hF; n_rob = 4'hF;
      if (i < 4) n_mem = 4'hF;
      expect_out(4'b1111, 1, 5'b00000, RUN);
    end
    tick(); enq = 4'h1; n_rob = 4'h1; n_mem = 4'h1; expect_out(4'b0000, 0, 5'b00101, RUN);

    @(negedge clk);
    #1;
    total_cnt++;
    if (exp_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL scoreboard_drain leftover=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/disp_credit_ctrl.md
# disp_credit_ctrl

Credit-based dispatch controller between rename and the dispatch resources: ROB, int dispatch queue, mem dispatch queue, imm buffer and branch buffer. It tracks free slots per resource and grants the longest in-order prefix of the rename group that fits. It sequences squash recovery so that nothing dispatches until all downstream owners have rebuilt their state. It drives the rename-side `o_can_enq` and per-slot dispatch enables.

## Interface
- `WIDTH`, 4: rename/dispatch group width.
- `ROB_DEPTH`, 64: ROB entries.
- `INTDQ_DEPTH`, 16: int dispatch queue entries.
- `MEMDQ_DEPTH`, 16: mem dispatch queue entries.
- `IMMB_DEPTH`, 30: imm buffer entries.
- `BRB_DEPTH`, 30: branch buffer entries.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_squash_vld`  in  1  pipeline squash.
- `i_recover_done`  in  1  all owners have finished squash recovery.
- `i_enq_vld`  in  WIDTH  rename slot valid; contiguous from bit 0.
- `i_need_rob`, `i_need_intdq`, `i_need_memdq`, `i_need_imm`, `i_need_br`  in  WIDTH each  per-slot resource demand.
- `i_ret_rob`, `i_ret_intdq`, `i_ret_memdq`, `i_ret_imm`, `i_ret_br`  in  $clog2(WIDTH+1) each  entries freed this cycle.
- `o_disp_vld`  out  WIDTH  slots granted this cycle; always a prefix.
- `o_can_enq`  out  1  every valid slot was granted.
- `o_stall_reason`  out  5  {br,imm,memdq,intdq,rob} blocked the first ungranted valid slot.
- `o_busy`  out  1  state is not RUN.

## Operation
- One credit register per resource, width $clog2(DEPTH+1).
- Reset value of each credit register is its DEPTH.
- FSM states:
  - INIT: entered on reset; lasts 1 cycle; then RUN.
  - RUN: normal dispatch; `i_squash_vld` takes it to FLUSH.
  - FLUSH: lasts 1 cycle; then RECOVER.
  - RECOVER: held until `i_recover_done`; then RUN.
- Grant rule, RUN only:
  - Slot k is granted iff slots 0..k are all valid.
  - For every resource, the popcount of `need[0..k]` must be ≤ that resource's credit.
  - `o_disp_vld` is a prefix mask; `o_can_enq` = (`o_disp_vld` == `i_enq_vld`).
- In INIT, FLUSH and RECOVER:
  - `o_disp_vld`=0 and `o_can_enq`=0.
  - `o_can_enq`=0 holds even when `i_enq_vld`=0.
- Credit update every cycle: `credit_next = credit - consumed + returned`.
  - consumed = popcount(`need & o_disp_vld`).
  - returned = `i_ret_*`.
- FLUSH:
  - intdq and memdq credits load DEPTH; both queues are flushed by the squash.
  - rob/imm/br credits keep their arithmetic.
- RECOVER: returns keep accumulating, so owners can hand back squashed entries by walking.
- `i_squash_vld` in any non-INIT state:
  - goes to FLUSH;
  - suppresses dispatch in the same cycle.
- `i_squash_vld` and `i_recover_done` in the same cycle: squash wins.
- Simulation assertions (error) on credit overflow:
  - returned > DEPTH - credit + consumed;
  - any `need` bit set on a slot where `i_enq_vld` is 0;
  - non-contiguous `i_enq_vld`.
- `o_stall_reason`:
  - one bit per resource that fails the check at the first valid, ungranted slot;
  - 0 when `o_can_enq`=1 or not in RUN.

## Timing
- Grant path is combinational from the registered credits, the current `i_enq_vld` and the `need_*` inputs.
- Same-cycle returns are not visible to grants; they take effect next cycle (1-cycle return latency).
- Reset outputs: `o_disp_vld`=0, `o_can_enq`=0, `o_stall_reason`=0, `o_busy`=1 (INIT).
- Minimum squash-to-dispatch latency:
  - FLUSH at edge+1;
  - RECOVER at edge+2;
  - first grant possible in the cycle after `i_recover_done` is sampled.
- A reset mid-RECOVER returns to INIT with full credits; pending returns are dropped.

## Structure
- Shared package:
  - state enum `dispCtrlState_t` {INIT, RUN, FLUSH, RECOVER};
  - stall-reason bit indices;
  - per-resource depth constants (`ROB_SIZE`, `INTDQ_SIZE`, `MEMDQ_SIZE`, `IMMB_SIZE`, `BRB_SIZE`) that feed the defaults.
- One sub-module, `credit_counter`, instantiated 5 times:
  - parameter DEPTH;
  - inputs: consume count, return count, load-full;
  - output: the credit value.

## Test plan
- Reset, then RUN, `i_enq_vld`=4'b1111, all `need_rob` set, no other needs → `o_disp_vld`=4'b1111; rob credit 64→60.
- Drain the intdq credit to 2 with no returns, then 4 slots all needing intdq → `o_disp_vld`=4'b0011, `o_can_enq`=0, `o_stall_reason`=5'b00010.
- Mixed need with imm credit 1, slot0 non-imm, slots 1 and 2 imm → `o_disp_vld`=4'b0011; slot 2 blocked, `o_stall_reason`=5'b01000.
- Same cycle: br credit 0 and `i_ret_br`=3 → no branch slot granted this cycle; next cycle br credit = 3 and the branch slot is granted.
- `i_squash_vld` with intdq credit 5 → next cycle FLUSH, intdq credit = 16, dispatch 0; hold `i_recover_done`=0 for 10 cycles → no grants, rob returns accumulate; `i_recover_done`=1 → RUN the following cycle.
- Squash and `i_recover_done` asserted together in RECOVER → FSM re-enters FLUSH.
- `rst` asserted mid-RECOVER → all credits at DEPTH, INIT, then RUN.
